// File: rtl/booth_pkg.sv
// Shared constants and sequencer state encoding for the Booth multiplier cluster.
package booth_pkg;

  localparam int BOOTH_N       = 8;
  localparam int BOOTH_TAG_W   = 4;
  localparam int BOOTH_TIMEOUT = 2 * BOOTH_N + 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_STRT,
    ST_LDM,
    ST_LDQ,
    ST_RUN,
    ST_OUT
  } seq_state_e;

endpackage

// File: rtl/booth_watchdog.sv
// Load/decrement down-counter with a terminal-count (zero) flag.
// The counter parks at zero rather than wrapping.
module booth_watchdog #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load wins over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/booth_job_sequencer.sv
// Runs one Booth multiply per job: clears the controller, starts it, feeds
// M then Q on the shared load bus, waits for done (bounded by a watchdog)
// and returns the {A,Q} product with the job tag over valid/ready.
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | ready for a job; captures m/q/tag on in_valid
// CLR     | one-cycle synchronous reset pulse to the controller
// STRT    | start pulse, M on the load bus
// LDM     | controller loads M
// LDQ     | controller loads Q; watchdog loaded
// RUN     | waiting for done or watchdog expiry
// OUT     | result held until the consumer takes it
module booth_job_sequencer
  import booth_pkg::*;
#(
  parameter int N       = BOOTH_N,
  parameter int TAG_W   = BOOTH_TAG_W,
  parameter int TIMEOUT = 2 * N + 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_m,
  input  logic [N-1:0]     in_q,
  input  logic [TAG_W-1:0] in_tag,
  output logic             mul_rst,
  output logic             mul_start,
  output logic [N-1:0]     mul_data,
  input  logic             mul_done,
  input  logic [N-1:0]     mul_a,
  input  logic [N-1:0]     mul_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_prod,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  seq_state_e       state_q, state_d;
  logic [N-1:0]     m_q, m_d;
  logic [N-1:0]     q_q, q_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [2*N-1:0]   prod_q, prod_d;
  logic             err_q, err_d;
  // Low through reset and until the first clock after release, so the
  // controller sees mul_rst and no job is accepted in that window.
  logic             alive_q;
  logic             wd_load, wd_dec, wd_zero;

  booth_watchdog #(.W(WD_W)) u_watchdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (wd_load),
    .load_val_i (WD_W'(TIMEOUT)),
    .dec_i      (wd_dec),
    .zero_o     (wd_zero)
  );

  // Next-state logic and job register updates (handshake edges only).
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    tag_d   = tag_q;
    prod_d  = prod_q;
    err_d   = err_q;
    wd_load = 1'b0;
    wd_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && alive_q) begin
          m_d     = in_m;
          q_d     = in_q;
          tag_d   = in_tag;
          state_d = ST_CLR;
        end
      end
      ST_CLR:  state_d = ST_STRT;
      ST_STRT: state_d = ST_LDM;
      ST_LDM:  state_d = ST_LDQ;
      ST_LDQ: begin
        wd_load = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // done beats an expiring watchdog in the same cycle
        if (mul_done) begin
          prod_d  = {mul_a, mul_q};
          err_d   = 1'b0;
          state_d = ST_OUT;
        end else if (wd_zero) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = ST_OUT;
        end else begin
          wd_dec = 1'b1;
        end
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and job registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      q_q     <= '0;
      tag_q   <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      tag_q   <= tag_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
      alive_q <= 1'b1;
    end
  end

  // Outputs decoded from state and registers only.
  always_comb begin
    mul_data = '0;
    case (state_q)
      ST_STRT, ST_LDM: mul_data = m_q;
      ST_LDQ, ST_RUN:  mul_data = q_q;
      default:         mul_data = '0;
    endcase
  end

  assign in_ready  = alive_q && (state_q == ST_IDLE);
  assign mul_rst   = !alive_q || (state_q == ST_CLR);
  assign mul_start = (state_q == ST_STRT);
  assign out_valid = (state_q == ST_OUT);
  assign out_prod  = prod_q;
  assign out_tag   = tag_q;
  assign out_err   = err_q;

endmodule
